// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: read-mode constants and sizing helpers.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(value)) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// FIFO storage: single write port, asynchronous read port, optional clear on reset.
module fifo_sync_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 4,
  parameter int unsigned RST_MEM = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int unsigned DEPTH = fifo_depth(AW);

  logic [DW-1:0] mem [DEPTH];

  // Writes are held off while reset is asserted; the array is only cleared when RST_MEM is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (RST_MEM != 0) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_v2.sv
// Single-clock FIFO with exact registered flags, programmable thresholds,
// sticky error flags, synchronous flush and selectable FWFT/standard read.
module fifo_sync_v2
  import fifo_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 4,
  parameter int unsigned FWFT    = 1,
  parameter int unsigned RST_MEM = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] din,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW:0]   prog_full_thr,
  input  logic [AW:0]   prog_empty_thr,
  input  logic          err_clr,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          full,
  output logic          al_full,
  output logic          prog_full,
  output logic          empty,
  output logic          al_empty,
  output logic          prog_empty,
  output logic [AW:0]   rd_count,
  output logic [AW:0]   wr_space,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned DEPTH = fifo_depth(AW);
  localparam int unsigned PW    = AW + 1;

  if (AW < 1) begin : g_bad_aw
    $fatal(1, "fifo_sync_v2: AW must be >= 1");
  end
  if (DW < 1) begin : g_bad_dw
    $fatal(1, "fifo_sync_v2: DW must be >= 1");
  end

  logic [PW-1:0] wr_p;
  logic [PW-1:0] rd_p;
  logic [PW-1:0] count;
  logic [PW-1:0] count_next;
  logic          wr_acc;
  logic          rd_acc;
  logic [DW-1:0] rd_data;

  // Acceptance looks only at the registered flags; flush overrides both requests.
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;
  assign count  = wr_p - rd_p;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + PW'(wr_acc) - PW'(rd_acc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_p <= '0;
      rd_p <= '0;
    end else if (flush) begin
      wr_p <= '0;
      rd_p <= '0;
    end else begin
      if (wr_acc) wr_p <= wr_p + PW'(1);
      if (rd_acc) rd_p <= rd_p + PW'(1);
    end
  end

  // Status registers are all loaded from count_next so they are exact one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full       <= 1'b0;
      al_full    <= 1'b0;
      prog_full  <= 1'b0;
      empty      <= 1'b1;
      al_empty   <= 1'b1;
      prog_empty <= 1'b1;
      rd_count   <= '0;
      wr_space   <= PW'(DEPTH);
    end else begin
      full       <= (count_next == PW'(DEPTH));
      al_full    <= (count_next >= PW'(DEPTH - 1));
      prog_full  <= (count_next >= prog_full_thr);
      empty      <= (count_next == '0);
      al_empty   <= (count_next <= PW'(1));
      prog_empty <= (count_next <= prog_empty_thr);
      rd_count   <= count_next;
      wr_space   <= PW'(DEPTH) - count_next;
    end
  end

  // A same-cycle rejection wins over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & full) | (overflow & ~err_clr);
      underflow <= (rd_en & empty) | (underflow & ~err_clr);
    end
  end

  fifo_sync_ram #(
    .DW      (DW),
    .AW      (AW),
    .RST_MEM (RST_MEM)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_p[AW-1:0]),
    .wr_data (din),
    .rd_addr (rd_p[AW-1:0]),
    .rd_data (rd_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign dout     = empty ? '0 : rd_data;
    assign dout_vld = ~empty;
  end else begin : g_std
    logic [DW-1:0] dout_q;
    logic          vld_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_acc;
        if (rd_acc) dout_q <= rd_data;
      end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
  end

endmodule
